// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative radix-2 multiply/divide with HI/LO register pair
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] mt_data,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, CALC, FINISH} state_t;
  state_t             state;
  logic [1:0]         opr;
  logic [WIDTH-1:0]   ma, mb;
  logic               sa, sb;
  logic [CW-1:0]      count;
  logic [2*WIDTH-1:0] acc, next_acc, prod;
  logic [WIDTH:0]     msum, dshift, ddiff;
  logic [WIDTH-1:0]   a_mag, b_mag, quo, rem, raw_a, fin_hi, fin_lo;
  logic               sgn, is_div, neg;
  assign busy   = state != IDLE;
  assign is_div = opr[1];
  assign sgn    = ~op[0];
  assign a_mag  = (sgn && operand_a[WIDTH-1]) ? -operand_a : operand_a;
  assign b_mag  = (sgn && operand_b[WIDTH-1]) ? -operand_b : operand_b;
  // acc holds {partial product, multiplier} for multiply and {remainder, quotient} for divide
  always_comb begin
    msum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, ma} : '0);
    dshift   = acc[2*WIDTH-1:WIDTH-1];
    ddiff    = dshift - {1'b0, mb};
    next_acc = !is_div ? {msum, acc[WIDTH-1:1]}
             : ddiff[WIDTH] ? {dshift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
             : {ddiff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    neg      = sa ^ sb;
    prod     = neg ? -acc : acc;
    quo      = neg ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem      = sa ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    raw_a    = sa ? -ma : ma;
    fin_hi   = !is_div ? prod[2*WIDTH-1:WIDTH] : (mb == '0) ? raw_a : rem;
    fin_lo   = !is_div ? prod[WIDTH-1:0] : (mb == '0) ? '1 : quo;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      hi    <= '0;
      lo    <= '0;
      done  <= 1'b0;
      count <= '0;
      acc   <= '0;
      opr   <= '0;
      ma    <= '0;
      mb    <= '0;
      sa    <= 1'b0;
      sb    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            opr   <= op;
            ma    <= a_mag;
            mb    <= b_mag;
            sa    <= sgn & operand_a[WIDTH-1];
            sb    <= sgn & operand_b[WIDTH-1];
            count <= '0;
            acc   <= {{WIDTH{1'b0}}, op[1] ? a_mag : b_mag};
            state <= CALC;
          end else begin
            if (mthi) hi <= mt_data;
            if (mtlo) lo <= mt_data;
          end
        end
        CALC: begin
          acc   <= next_acc;
          count <= count + 1'b1;
          if (count == CW'(WIDTH - 1)) state <= FINISH;
        end
        FINISH: begin
          hi    <= fin_hi;
          lo    <= fin_lo;
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed and random checks of muldiv_unit against an arithmetic model
module tb_muldiv_unit;
  logic        clk = 0, rst = 1, start = 0, mthi = 0, mtlo = 0;
  logic [1:0]  op = 0;
  logic [31:0] operand_a = 0, operand_b = 0, mt_data = 0;
  logic        busy, done;
  logic [31:0] hi, lo;
  int errors = 0, checks = 0;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op),
    .operand_a(operand_a), .operand_b(operand_b),
    .mthi(mthi), .mtlo(mtlo), .mt_data(mt_data),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] model(logic [1:0] o, logic [31:0] a, logic [31:0] b);
    longint p;
    int sa, sb;
    sa = int'(a);
    sb = int'(b);
    if (o == 2'd0) begin
      p = longint'(sa) * longint'(sb);
      return p;
    end
    if (o == 2'd1) return {32'b0, a} * {32'b0, b};
    if (b == 0) return {a, 32'hFFFF_FFFF};
    if (o == 2'd3) return {a % b, a / b};
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
    return {32'(sa % sb), 32'(sa / sb)};
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic launch(logic [1:0] o, logic [31:0] a, logic [31:0] b);
    @(negedge clk);
    op = o; operand_a = a; operand_b = b; start = 1;
    @(posedge clk); #1;
    start = 0;
    chk("busy_after_start", 64'(busy), 64'd1);
    operand_a = $urandom; operand_b = $urandom; op = 2'($urandom);
  endtask

  task automatic wait_done(int n0, output int lat);
    int n = n0;
    while (done !== 1'b1 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    lat = n;
  endtask

  task automatic do_op(string tag, logic [1:0] o, logic [31:0] a, logic [31:0] b);
    logic [63:0] e = model(o, a, b);
    int lat;
    launch(o, a, b);
    wait_done(0, lat);
    chk({tag, "_latency"}, 64'(lat), 64'd33);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_hilo"}, {hi, lo}, e);
  endtask

  initial begin
    int lat, ndone;
    logic [63:0] e;
    logic [31:0] a, b;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", {30'b0, busy, done, hi, lo}, 64'd0);
    @(negedge clk);
    rst = 0;

    do_op("mult_neg1x2", 2'd0, 32'hFFFF_FFFF, 32'h0000_0002);
    do_op("multu_max", 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    do_op("div_m7_2", 2'd2, 32'hFFFF_FFF9, 32'd2);
    do_op("divu_7_2", 2'd3, 32'd7, 32'd2);
    do_op("div_by_zero", 2'd2, 32'h1234_5678, 32'd0);
    do_op("div_overflow", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    do_op("div_neg_by_zero", 2'd2, 32'hFFFF_FF00, 32'd0);
    do_op("divu_by_zero", 2'd3, 32'h8765_4321, 32'd0);
    @(posedge clk); #1;
    chk("done_one_cycle", 64'(done), 64'd0);

    // second start and mthi while busy must not disturb the running op
    e = model(2'd2, 32'hFFFF_FF85, 32'd10);
    launch(2'd2, 32'hFFFF_FF85, 32'd10);
    repeat (4) @(posedge clk);
    @(negedge clk);
    op = 2'd1; operand_a = 32'd3; operand_b = 32'd5; start = 1;
    @(posedge clk); #1;
    start = 0;
    @(negedge clk);
    mthi = 1; mt_data = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    mthi = 0;
    wait_done(6, lat);
    chk("busy_ignore_latency", 64'(lat), 64'd33);
    chk("busy_ignore_hilo", {hi, lo}, e);
    @(negedge clk);
    mtlo = 1; mt_data = 32'hA5A5_A5A5;
    @(posedge clk); #1;
    mtlo = 0;
    chk("mtlo_idle", {hi, lo}, {e[63:32], 32'hA5A5_A5A5});
    @(negedge clk);
    mthi = 1; mtlo = 1; mt_data = 32'h1357_9BDF;
    @(posedge clk); #1;
    mthi = 0; mtlo = 0;
    chk("mthi_mtlo_both", {hi, lo}, {2{32'h1357_9BDF}});

    // start beats mthi in the same idle cycle
    @(negedge clk);
    op = 2'd1; operand_a = 32'd3; operand_b = 32'd5; start = 1; mthi = 1; mt_data = 32'hCAFE_F00D;
    @(posedge clk); #1;
    start = 0; mthi = 0;
    chk("start_wins_hi", 64'(hi), 64'h1357_9BDF);
    wait_done(0, lat);
    chk("start_wins_hilo", {hi, lo}, 64'd15);

    for (int i = 0; i < 30; i++) begin
      a = $urandom;
      b = $urandom;
      if (i % 5 == 1) b = 32'($urandom_range(0, 20));
      if (i % 7 == 3) b = 0;
      if (i % 4 == 2) b = -b;
      do_op("random", 2'(i % 4), a, b);
    end

    // reset mid-operation discards it with no done pulse
    launch(2'd0, 32'h0000_1234, 32'h0000_5678);
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst = 1;
    @(posedge clk); #1;
    chk("rst_mid_op", {31'b0, busy, hi, lo}, 64'd0);
    @(negedge clk);
    rst = 0;
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    chk("rst_no_done", 64'(ndone), 64'd0);
    chk("rst_idle_after", {31'b0, busy, hi, lo}, 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
